// File: rtl/multiprecision_add_sequencer.sv
// Multi-cycle wide adder: one narrow carry-select adder is reused slice by slice, LSB first,
// with the inter-slice carry held in a register. Valid/ready handshakes on both sides.

module carry_select_adder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int unsigned NumBlocks = WIDTH / BLOCK_SIZE;

  logic [NumBlocks:0] carry;

  assign carry[0] = cin_i;

  // Each block precomputes both carry-in outcomes; the rippling carry only drives muxes.
  for (genvar g = 0; g < NumBlocks; g++) begin : g_blk
    logic [BLOCK_SIZE:0] s0;
    logic [BLOCK_SIZE:0] s1;

    assign s0 = {1'b0, a_i[g*BLOCK_SIZE +: BLOCK_SIZE]} + {1'b0, b_i[g*BLOCK_SIZE +: BLOCK_SIZE]};
    assign s1 = {1'b0, a_i[g*BLOCK_SIZE +: BLOCK_SIZE]} + {1'b0, b_i[g*BLOCK_SIZE +: BLOCK_SIZE]}
              + (BLOCK_SIZE+1)'(1);

    assign sum_o[g*BLOCK_SIZE +: BLOCK_SIZE] = carry[g] ? s1[BLOCK_SIZE-1:0] : s0[BLOCK_SIZE-1:0];
    assign carry[g+1]                        = carry[g] ? s1[BLOCK_SIZE] : s0[BLOCK_SIZE];
  end

  assign cout_o = carry[NumBlocks];

endmodule

module multiprecision_add_sequencer #(
  parameter int unsigned OP_WIDTH    = 32,
  parameter int unsigned SLICE_WIDTH = 8,
  parameter int unsigned BLOCK_SIZE  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] in_a,
  input  logic [OP_WIDTH-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] out_sum,
  output logic                out_cout,
  output logic                out_overflow
);
  localparam int unsigned NUM_SLICES = OP_WIDTH / SLICE_WIDTH;
  localparam int unsigned IdxW       = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SLICES - 1);

  if ((OP_WIDTH % SLICE_WIDTH) != 0) begin : g_bad_op_width
    $error("OP_WIDTH must be a multiple of SLICE_WIDTH");
  end
  if ((SLICE_WIDTH % BLOCK_SIZE) != 0) begin : g_bad_slice_width
    $error("SLICE_WIDTH must be a multiple of BLOCK_SIZE");
  end
  if (NUM_SLICES < 1) begin : g_bad_num_slices
    $error("NUM_SLICES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [OP_WIDTH-1:0]   a_q, a_d;
  logic [OP_WIDTH-1:0]   b_q, b_d;
  logic [OP_WIDTH-1:0]   sum_q, sum_d;
  logic                  cout_q, cout_d;
  logic                  ovf_q, ovf_d;

  logic [SLICE_WIDTH-1:0] slice_a;
  logic [SLICE_WIDTH-1:0] slice_b;
  logic [SLICE_WIDTH-1:0] slice_sum;
  logic                   slice_cout;

  assign slice_a = a_q[idx_q*SLICE_WIDTH +: SLICE_WIDTH];
  assign slice_b = b_q[idx_q*SLICE_WIDTH +: SLICE_WIDTH];

  carry_select_adder #(
    .WIDTH      (SLICE_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_adder (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*SLICE_WIDTH +: SLICE_WIDTH] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = slice_cout;
          // Sign bits of b_q are already inverted for subtract.
          ovf_d   = (a_q[OP_WIDTH-1] == b_q[OP_WIDTH-1]) &&
                    (slice_sum[SLICE_WIDTH-1] != a_q[OP_WIDTH-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign out_sum      = sum_q;
  assign out_cout     = cout_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_multiprecision_add_sequencer.sv
// Directed bench for multiprecision_add_sequencer at the default 32/8/4 configuration.

module tb_multiprecision_add_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;

  multiprecision_add_sequencer #(
    .OP_WIDTH    (32),
    .SLICE_WIDTH (8),
    .BLOCK_SIZE  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cin       (in_cin),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_cout     (out_cout),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command from IDLE; lat counts edges from the accepting edge to out_valid.
  task automatic do_cmd(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output int lat);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 0", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", out_cout); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", out_overflow); end
  endtask

  task automatic test_carry_ripple();
    int lat;
    out_ready = 1'b1;
    do_cmd(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL ripple_latency got %0d want 5", lat); end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL ripple_sum got %h want 00000000", out_sum); end
    checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL ripple_cout got %b want 1", out_cout); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ripple_ovf got %b want 0", out_overflow); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ripple_after_xfer in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_subtract();
    int lat;
    out_ready = 1'b1;
    for (int c = 1; c >= 0; c--) begin
      do_cmd(32'd5, 32'd7, c[0], 1'b1, lat);
      checks++; if (lat != 5) begin errors++; $display("FAIL sub_latency cin=%0d got %0d want 5", c, lat); end
      checks++; if (out_sum !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_sum cin=%0d got %h want fffffffe", c, out_sum); end
      checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL sub_cout cin=%0d got %b want 0", c, out_cout); end
      checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL sub_ovf cin=%0d got %b want 0", c, out_overflow); end
      tick();
    end
  endtask

  task automatic test_overflow();
    int lat;
    out_ready = 1'b1;
    do_cmd(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    checks++; if (out_sum !== 32'h8000_0000) begin errors++; $display("FAIL ovf_add_sum got %h want 80000000", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL ovf_add_cout got %b want 0", out_cout); end
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_add_ovf got %b want 1", out_overflow); end
    tick();
    do_cmd(32'h8000_0000, 32'h1, 1'b0, 1'b1, lat);
    checks++; if (out_sum !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_sub_sum got %h want 7fffffff", out_sum); end
    checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL ovf_sub_cout got %b want 1", out_cout); end
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sub_ovf got %b want 1", out_overflow); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    do_cmd(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL bp_latency got %0d want 5", lat); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h2345_6789) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stall_stable bad_cycles=%0d want 0", bad); end
    checks++; if (out_valid !== 1'b1 || out_sum !== 32'h2345_6789) begin
      errors++; $display("FAIL bp_still_held valid=%b sum=%h want 1/23456789", out_valid, out_sum);
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_single_xfer valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    checks++; if (out_sum !== 32'h2345_6789) begin errors++; $display("FAIL bp_sum_hold got %h want 23456789", out_sum); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    out_ready = 1'b1;
    in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++; if (out_sum !== 32'h0 || out_cout !== 1'b0 || out_overflow !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs sum=%h cout=%b ovf=%b want 0/0/0", out_sum, out_cout, out_overflow);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_valid got %0d want 0", seen); end
    do_cmd(32'd1, 32'd2, 1'b0, 1'b0, lat);
    checks++; if (lat != 5 || out_sum !== 32'd3) begin
      errors++; $display("FAIL midrst_next lat=%0d sum=%h want 5/00000003", lat, out_sum);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vc [3];
    logic [32:0] ref_sum;
    int acc_cyc [3];
    int n_acc;
    int n_res;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      va[i] = $urandom();
      vb[i] = $urandom();
      vc[i] = 1'($urandom_range(1, 0));
    end
    out_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    cyc = 0;
    in_a = va[0]; in_b = vb[0]; in_cin = vc[0]; in_sub = 1'b0; in_valid = 1'b1;
    while (n_res < 3 && cyc < 100) begin
      if (out_valid) begin
        ref_sum = {1'b0, va[n_res]} + {1'b0, vb[n_res]} + {32'h0, vc[n_res]};
        checks++; if (out_sum !== ref_sum[31:0] || out_cout !== ref_sum[32]) begin
          errors++; $display("FAIL b2b_result%0d got %h/%b want %h/%b", n_res, out_sum, out_cout,
                             ref_sum[31:0], ref_sum[32]);
        end
        n_res++;
      end
      if (in_ready && in_valid) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        tick();
        cyc++;
        if (n_acc < 3) begin
          in_a = va[n_acc]; in_b = vb[n_acc]; in_cin = vc[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        tick();
        cyc++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n_res != 3 || n_acc != 3) begin
      errors++; $display("FAIL b2b_count results=%0d accepts=%0d want 3/3", n_res, n_acc);
    end else begin
      checks++; if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
        errors++; $display("FAIL b2b_spacing got %0d,%0d want 6,6", acc_cyc[1] - acc_cyc[0],
                           acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_carry_ripple();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiprecision_add_sequencer.md
Name: multiprecision_add_sequencer

Overview:
- Adds two OP_WIDTH-bit operands over several cycles, reusing one SLICE_WIDTH-bit carry_select_adder.
- The sequencer registers the operands and feeds one slice per cycle, LSB slice first.
- The carry is kept in a register and fed into the next slice.
- Upstream and downstream use valid/ready handshakes. Wide arithmetic therefore costs one narrow adder plus registers.

Parameters:
- OP_WIDTH, 32, operand/result width in bits.
- SLICE_WIDTH, 8, width of the shared adder; passed as WIDTH to carry_select_adder.
- BLOCK_SIZE, 4, passed to carry_select_adder.
- Derived localparam NUM_SLICES = OP_WIDTH/SLICE_WIDTH.
- Elaboration error if OP_WIDTH % SLICE_WIDTH != 0, SLICE_WIDTH % BLOCK_SIZE != 0, or NUM_SLICES < 1.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/command valid
- in_ready  output  1  sequencer can accept a command
- in_a  input  OP_WIDTH  operand A
- in_b  input  OP_WIDTH  operand B
- in_cin  input  1  carry-in; ignored when in_sub=1
- in_sub  input  1  1: compute A-B as A+~B+1
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  OP_WIDTH  result
- out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- out_overflow  output  1  two's-complement overflow

Behaviour:
- Reset state:
  - state=IDLE, slice index=0, carry_reg=0, operand/result registers=0.
  - in_ready=1 in the first cycle after reset. out_valid=0, out_sum=0, out_cout=0, out_overflow=0.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are registered/state-decoded; neither depends combinationally on the other side.
- IDLE, on in_valid&in_ready at edge T:
  - a_reg<=in_a; b_reg<=in_sub ? ~in_b : in_b; carry_reg<=in_sub ? 1 : in_cin; idx<=0; state<=RUN.
  - Without in_valid, stay in IDLE; registers hold.
- RUN, one slice per cycle. Slice k is processed in cycle T+1+k, k=0..NUM_SLICES-1.
  - Adder inputs: a_reg[k*SLICE_WIDTH +: SLICE_WIDTH], the matching b_reg slice, cin=carry_reg.
  - At the edge: that sum_reg slice <= adder sum; carry_reg <= adder cout; idx<=idx+1.
  - When k=NUM_SLICES-1:
    - out_cout <= adder cout.
    - out_overflow <= (a_msb==b_msb) && (sum_msb!=a_msb), using slice MSBs of a_reg/b_reg (b already inverted for subtract).
    - state<=DONE; idx wraps to 0.
- DONE:
  - out_valid=1. out_sum/out_cout/out_overflow are stable while out_valid=1 and out_ready=0 (no limit on stall length).
  - On out_valid&out_ready: state<=IDLE.
- Latency: accept at edge T -> out_valid high in cycle T+NUM_SLICES+1. Minimum accept-to-accept spacing is NUM_SLICES+2 cycles; there is no overlap of commands.
- in_* changes while not IDLE are ignored; operands are captured only on acceptance.
- NUM_SLICES=1: RUN lasts exactly one cycle.
- Reset mid-operation (any state):
  - The in-flight command is discarded and no out_valid is produced for it.
  - Next cycle: IDLE, in_ready=1, outputs zeroed.
- out_sum holds its value after handshake until the next result overwrites it (not cleared except by rst).

Test Plan (defaults: OP_WIDTH=32, SLICE_WIDTH=8, so NUM_SLICES=4):
1. Carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> out_valid exactly 5 cycles after acceptance; sum=0x00000000, cout=1, overflow=0; in_ready returns 1 the cycle after transfer.
2. Subtract with borrow: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, overflow=0; repeat with cin=0 and confirm the result is unchanged (cin ignored).
3. Signed overflow: a=0x7FFFFFFF, b=1, sub=0, cin=0 -> sum=0x80000000, cout=0, overflow=1. Also a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
4. Backpressure: a=0x12345678, b=0x11111111, out_ready held 0 for 6 cycles after out_valid -> sum=0x23456789 stable throughout, in_ready=0; out_ready=1 -> single transfer, IDLE next cycle.
5. Reset mid-RUN: accept a=0xAAAAAAAA, b=0x55555555, assert rst in cycle T+2 -> no out_valid ever for this command; in_ready=1 and all outputs 0 the cycle after rst. A following command a=1, b=2 -> sum=3.
6. Back-to-back: in_valid held 1 with 3 different random operand pairs, out_ready=1 -> accepts exactly 6 cycles apart; each sum matches a reference model (a+b+cin mod 2^32).
